pll_clk_monitor: RTL and testbench
==================================

// Module: pll_clk_monitor
// PURPOSE
// - Qualifies the 199.8 MHz system PLL (27 MHz in, x37/5) before downstream logic runs; consumer end of the PLL LOCK/CLKOUT interface.
// - Runs in the 27 MHz reference domain. Measures a toggle derived from the PLL output (external /64 toggle flop in the PLL domain) over fixed windows.
// - Combines the frequency check with synchronized LOCK; drives the downstream active-low reset and status.
// PARAMETERS
// - WINDOW     2700   ref cycles per measurement window (100 us)
// - EXP_COUNT  312    expected toggle transitions per window (199.8 MHz / 64 * 100 us)
// - TOL        8      accepted deviation; pass if |count - EXP_COUNT| <= TOL
// - SETTLE     27000  ref cycles of stable lock before the first measurement (1 ms)
// - RETRY      270000 ref cycles spent in FAULT before re-qualifying (macro only)
// - CNT_W      16     width of window/transition counters and freq_count
// PORTS
// - clk        in   1      27 MHz reference clock
// - rst_n      in   1      async active-low reset
// - pll_lock   in   1      PLL LOCK, asynchronous; 2-FF synchronized
// - pll_tog    in   1      PLL-domain /64 toggle, asynchronous; 2-FF synchronized
// - rst_out_n  out  1      downstream reset, active low, registered
// - pll_ok     out  1      1 while in RUN
// - fault      out  1      sticky error flag; cleared only by rst_n (or retry pass)
// - freq_count out  CNT_W  transition count of last completed window
// BEHAVIOUR
// - Reset values: rst_out_n=0, pll_ok=0, fault=0, freq_count=0; FSM=WAIT_LOCK; sync flops=0.
// - lock_s/tog_s: 2-FF synchronizers; edge = tog_s XOR its previous registered value (3rd flop).
// - FSM states: WAIT_LOCK, SETTLE, MEASURE, RUN, FAULT.
//   WAIT_LOCK: lock_s=1 -> SETTLE (settle counter cleared).
//   SETTLE: lock_s=0 -> WAIT_LOCK; counter reaches SETTLE-1 -> MEASURE (window and edge counters cleared).
//   MEASURE: one window; lock_s=0 -> FAULT; at window end pass -> RUN, fail -> FAULT.
//   RUN: windows repeat back-to-back; lock_s=0 or any failed window -> FAULT.
//   FAULT: terminal unless PLLMON_AUTO_RETRY_EN.
// - Window: counter runs 0..WINDOW-1; on WINDOW-1 the edge detected that same cycle is included, freq_count <= total, edge counter restarts at 0 next cycle (no lost or double-counted edges).
// - Edge counter saturates at 2^CNT_W-1 (no wrap); saturated value fails the range check.
// - Range check: EXP_COUNT-TOL <= count <= EXP_COUNT+TOL, inclusive, unsigned, computed in CNT_W+1 bits.
// - Simultaneous lock loss and passing window end: lock loss wins -> FAULT.
// - rst_out_n: goes 1 on the cycle after entering RUN; goes 0 on the same edge that enters FAULT or leaves RUN.
// - pll_ok mirrors state==RUN, registered; fault set on entry to FAULT.
// - Latency: pll_lock rise -> SETTLE entered 3 clk later; rst_out_n release >= SETTLE+WINDOW+4 clk after lock rise.
// - rst_n asserted mid-operation: all outputs to reset values immediately (async), counters cleared.
// CONFIGURATION
// - PLLMON_AUTO_RETRY_EN defined: FAULT counts RETRY cycles then -> WAIT_LOCK; fault stays 1 until a later MEASURE passes, then clears on RUN entry.
// - PLLMON_AUTO_RETRY_EN undefined: FAULT is terminal until rst_n; RETRY unused, no retry counter synthesized.
// TESTING
// - Nominal: lock=1 at t0, toggle 312/window -> rst_out_n=1, pll_ok=1 after SETTLE+WINDOW+4 clk; freq_count=312.
// - No lock: pll_lock held 0 for 100k clk -> state WAIT_LOCK, rst_out_n=0, fault=0.
// - Boundaries: windows of 304 and 320 -> pass; 303 or 321 in RUN -> fault=1, rst_out_n=0 same edge as FAULT entry.
// - Lock glitch: 3-clk low pulse on pll_lock in RUN -> FAULT; same pulse during SETTLE -> WAIT_LOCK, fault=0.
// - Lock drop on final window cycle with count 312 -> FAULT, not RUN; edge on cycle WINDOW-1 counted in that window.
// - With PLLMON_AUTO_RETRY_EN, RETRY=100: fault then nominal toggle -> RUN re-entered, fault cleared; without macro -> stays FAULT.

Source files
------------

// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor: qualifies the system PLL from the 27 MHz reference domain.
// The LOCK signal is synchronized. A /64 toggle from the PLL domain is also
// synchronized, and its transitions are counted over fixed windows. The
// downstream active-low reset is released only after a settle period and one
// window whose count is in range. It drops again on lock loss or on any failing
// window.
// Optional feature macro: PLLMON_AUTO_RETRY_EN. When it is defined, FAULT waits
// RETRY cycles and then re-qualifies. Otherwise FAULT is terminal until rst_n.
// There is no handshake. All inputs are level or edge signals sampled every
// clk, and all outputs are registered levels.
// dbg_state encoding: 0 WAIT_LOCK, 1 SETTLE, 2 MEASURE, 3 RUN, 4 FAULT.
module pll_clk_monitor #(
  parameter int WINDOW    = 2700,
  parameter int EXP_COUNT = 312,
  parameter int TOL       = 8,
  parameter int SETTLE    = 27000,
`ifdef PLLMON_AUTO_RETRY_EN
  parameter int RETRY     = 270000,
`endif
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             pll_tog,
  output logic             rst_out_n,
  output logic             pll_ok,
  output logic             fault,
  output logic [CNT_W-1:0] freq_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_SETTLE    = 3'd1,
    S_MEASURE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  // Acceptance band, one bit wider than the counter so that EXP+TOL cannot wrap.
  localparam logic [CNT_W:0] LO = (EXP_COUNT > TOL) ? (CNT_W+1)'(EXP_COUNT - TOL) : '0;
  localparam logic [CNT_W:0] HI = (CNT_W+1)'(EXP_COUNT + TOL);
`ifdef PLLMON_AUTO_RETRY_EN
  localparam int RTY_W = $clog2(RETRY + 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY - 1);
  logic [RTY_W-1:0] retry_q, retry_d;
`endif

  logic lock_meta_q, lock_s_q, tog_meta_q, tog_s_q, tog_prev_q;
  logic tog_chg;
  state_t state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic rst_out_q, rst_out_d, pll_ok_q, pll_ok_d, fault_q, fault_d;
  logic [CNT_W-1:0] ecnt_sum;
  logic win_end, in_range;

  // Two-flop synchronizers for LOCK and the toggle, plus a third toggle flop for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      tog_meta_q  <= 1'b0;
      tog_s_q     <= 1'b0;
      tog_prev_q  <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      tog_meta_q  <= pll_tog;
      tog_s_q     <= tog_meta_q;
      tog_prev_q  <= tog_s_q;
    end
  end

  assign tog_chg = tog_s_q ^ tog_prev_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_LOCK;
      settle_q  <= '0;
      win_q     <= '0;
      ecnt_q    <= '0;
      freq_q    <= '0;
      rst_out_q <= 1'b0;
      pll_ok_q  <= 1'b0;
      fault_q   <= 1'b0;
`ifdef PLLMON_AUTO_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      win_q     <= win_d;
      ecnt_q    <= ecnt_d;
      freq_q    <= freq_d;
      rst_out_q <= rst_out_d;
      pll_ok_q  <= pll_ok_d;
      fault_q   <= fault_d;
`ifdef PLLMON_AUTO_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  // Next state, window accounting and next output values.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    ecnt_d   = ecnt_q;
    freq_d   = freq_q;
`ifdef PLLMON_AUTO_RETRY_EN
    retry_d  = retry_q;
`endif
    // The edge seen this cycle is added before the window closes. The count saturates instead of wrapping.
    ecnt_sum = (ecnt_q == '1) ? ecnt_q : ecnt_q + CNT_W'(tog_chg);
    win_end  = (win_q == WIN_LAST);
    in_range = ({1'b0, ecnt_sum} >= LO) && ({1'b0, ecnt_sum} <= HI);

    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (settle_q == SET_LAST) begin
          state_d = S_MEASURE;
          win_d   = '0;
          ecnt_d  = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_MEASURE, S_RUN: begin
        if (win_end) begin
          win_d  = '0;
          ecnt_d = '0;
          freq_d = ecnt_sum;
        end else begin
          win_d  = win_q + CNT_W'(1);
          ecnt_d = ecnt_sum;
        end
        // Lock loss takes priority over a passing window end.
        if (!lock_s_q)    state_d = S_FAULT;
        else if (win_end) state_d = in_range ? S_RUN : S_FAULT;
      end
      S_FAULT: begin
`ifdef PLLMON_AUTO_RETRY_EN
        if (retry_q == RTY_LAST) state_d = S_WAIT_LOCK;
        else                     retry_d = retry_q + RTY_W'(1);
`else
        state_d = S_FAULT;
`endif
      end
      default: state_d = S_WAIT_LOCK;
    endcase

    // rst_out_n is released one cycle after RUN is entered and drops on the edge that leaves RUN.
    rst_out_d = (state_q == S_RUN) && (state_d == S_RUN);
    pll_ok_d  = (state_d == S_RUN);
    fault_d   = fault_q | ((state_d == S_FAULT) && (state_q != S_FAULT));
`ifdef PLLMON_AUTO_RETRY_EN
    if ((state_d == S_FAULT) && (state_q != S_FAULT)) retry_d = '0;
    if ((state_d == S_RUN) && (state_q != S_RUN))     fault_d = 1'b0;
`endif
  end

  assign rst_out_n  = rst_out_q;
  assign pll_ok     = pll_ok_q;
  assign fault      = fault_q;
  assign freq_count = freq_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pll_clk_monitor.sv
// Bench for pll_clk_monitor with a shortened window and settle time.
// Each scenario is planned on a timeline from the design rules. The expected
// output snapshots are queued with the cycle at which they must hold, and the
// per-cycle input stream (lock level, toggle flips) is then played. A monitor
// compares the DUT against the queued snapshot at each of those cycles.
module tb_pll_clk_monitor;
  localparam int W = 64, EXP = 16, TOL = 3, SET = 40, RETRY = 100, CNT_W = 16, MAXC = 4096;
  localparam logic [2:0] ST_WAIT = 3'd0, ST_SET = 3'd1, ST_MEAS = 3'd2, ST_RUN = 3'd3, ST_FAULT = 3'd4;

  logic clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, pll_tog = 1'b0;
  logic rst_out_n, pll_ok, fault;
  logic [CNT_W-1:0] freq_count;
  logic [2:0] dbg_state;

  pll_clk_monitor #(
    .WINDOW(W), .EXP_COUNT(EXP), .TOL(TOL), .SETTLE(SET),
`ifdef PLLMON_AUTO_RETRY_EN
    .RETRY(RETRY),
`endif
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_tog(pll_tog),
    .rst_out_n(rst_out_n), .pll_ok(pll_ok), .fault(fault),
    .freq_count(freq_count), .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int scen;
    logic [2:0] st;
    logic [CNT_W-1:0] fc;
    logic ok;
    logic rstn;
    logic flt;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0, scen = 0, base = 0, max_rel = 0;
  logic lock_arr [MAXC];
  logic flip_arr [MAXC];
  int c [8];

  function automatic bit pass_cnt(input int n);
    int d;
    d = n - EXP;
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  task automatic push(input int rel, input logic [2:0] st, input int fc,
                      input logic ok, input logic rstn, input logic flt);
    exp_t e;
    e.cyc = base + rel; e.scen = scen; e.st = st; e.fc = fc[CNT_W-1:0];
    e.ok = ok; e.rstn = rstn; e.flt = flt;
    exp_q.push_back(e);
    if (rel > max_rel) max_rel = rel;
  endtask

  // Scoreboard monitor: compares every queued snapshot due at this cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        n_cmp++;
        if (dbg_state !== exp_q[i].st || freq_count !== exp_q[i].fc || pll_ok !== exp_q[i].ok ||
            rst_out_n !== exp_q[i].rstn || fault !== exp_q[i].flt) begin
          n_err++;
          $display("FAIL snapshot scen%0d rel%0d: got st=%0d fc=%0d ok=%b rstn=%b flt=%b, want st=%0d fc=%0d ok=%b rstn=%b flt=%b",
                   exp_q[i].scen, exp_q[i].cyc - base, dbg_state, freq_count, pll_ok, rst_out_n, fault,
                   exp_q[i].st, exp_q[i].fc, exp_q[i].ok, exp_q[i].rstn, exp_q[i].flt);
        end
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missed_snapshot scen%0d cyc%0d: not checked, now cyc%0d", exp_q[i].scen, exp_q[i].cyc, cyc);
        exp_q.delete(i);
      end
    end
  end

  // Driver: asynchronous reset mid-cycle, immediate check of reset values, release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pll_lock = 1'b0; pll_tog = 1'b0;
    #1;
    n_cmp++;
    if (rst_out_n !== 1'b0 || pll_ok !== 1'b0 || fault !== 1'b0 || freq_count !== '0 || dbg_state !== ST_WAIT) begin
      n_err++;
      $display("FAIL reset_values before scen%0d: got rstn=%b ok=%b flt=%b fc=%0d st=%0d, want 0 0 0 0 0",
               scen + 1, rst_out_n, pll_ok, fault, freq_count, dbg_state);
    end
    while (exp_q.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL leftover_snapshot scen%0d cyc%0d: never checked", exp_q[0].scen, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = cyc; max_rel = 0; scen++;
  endtask

  // Plans n toggle transitions in the window whose cycle 0 is at rel cycle 'start'.
  // Window cycles 0 and W-1 always carry an edge. A flip driven at rel cycle t is
  // seen by the counter two synchronizer stages later, at window cycle t+2-start.
  task automatic place_window(input int start, input int n);
    int pos [W];
    int r, t;
    for (int k = 0; k < W; k++) pos[k] = k;
    for (int k = W - 2; k > 1; k--) begin
      r = $urandom_range(k, 1);
      t = pos[k]; pos[k] = pos[r]; pos[r] = t;
    end
    flip_arr[start - 2] = 1'b1;
    flip_arr[start + W - 3] = 1'b1;
    for (int k = 1; k <= n - 2; k++) flip_arr[start + pos[k] - 2] = 1'b1;
  endtask

  // mode: 0 none, 1 lock glitch during SETTLE, 2 lock glitch mid window jd,
  // 3 lock drop seen on the last cycle of window jd.
  task automatic run_scen(input int lrise, input int nwin, input int cnts [8], input int mode, input int jd);
    int m, e, d, f, m2, prev_fc, fault_fc;
    bit faulted;
    do_reset();
    for (int i = 0; i < MAXC; i++) begin
      lock_arr[i] = (lrise >= 0) && (i >= lrise);
      flip_arr[i] = 1'b0;
    end
    if (lrise < 0) begin
      push(100, ST_WAIT, 0, 0, 0, 0);
      push(1000, ST_WAIT, 0, 0, 0, 0);
      push(1990, ST_WAIT, 0, 0, 0, 0);
    end else begin
      if (mode == 1) begin
        d = lrise + 10;
        for (int i = d; i < d + 3; i++) lock_arr[i] = 1'b0;
        push(d + 2, ST_SET, 0, 0, 0, 0);
        push(d + 3, ST_WAIT, 0, 0, 0, 0);
        m = d + 6 + SET;
      end else begin
        m = lrise + 3 + SET;
      end
      push(m - 1, ST_SET, 0, 0, 0, 0);
      push(m, ST_MEAS, 0, 0, 0, 0);
      prev_fc = 0; fault_fc = 0; faulted = 1'b0; f = 0;
      for (int j = 0; j < nwin && !faulted; j++) begin
        place_window(m + j * W, cnts[j]);
        e = m + (j + 1) * W;
        if (mode == 2 && j == jd) begin
          d = m + j * W + 18;
          for (int i = d; i < d + 3; i++) lock_arr[i] = 1'b0;
          f = d + 3;
          push(f - 1, (j == 0) ? ST_MEAS : ST_RUN, prev_fc, j > 0, j > 0, 0);
          push(f, ST_FAULT, prev_fc, 0, 0, 1);
          fault_fc = prev_fc; faulted = 1'b1;
        end else if (mode == 3 && j == jd) begin
          d = e - 3;
          for (int i = d; i < d + 3; i++) lock_arr[i] = 1'b0;
          f = e;
          push(e - 1, (j == 0) ? ST_MEAS : ST_RUN, prev_fc, j > 0, j > 0, 0);
          push(e, ST_FAULT, cnts[j], 0, 0, 1);
          fault_fc = cnts[j]; faulted = 1'b1;
        end else begin
          if (j > 0) push(e - 1, ST_RUN, prev_fc, 1, 1, 0);
          if (pass_cnt(cnts[j])) begin
            push(e, ST_RUN, cnts[j], 1, j > 0, 0);
            if (j == 0) push(e + 1, ST_RUN, cnts[j], 1, 1, 0);
          end else begin
            push(e, ST_FAULT, cnts[j], 0, 0, 1);
            f = e; fault_fc = cnts[j]; faulted = 1'b1;
          end
          prev_fc = cnts[j];
        end
      end
      if (faulted) begin
        m2 = f + RETRY + 1 + SET;
        place_window(m2, EXP);
        place_window(m2 + W, EXP);
`ifdef PLLMON_AUTO_RETRY_EN
        push(m2 - 1, ST_SET, fault_fc, 0, 0, 1);
        push(m2 + W, ST_RUN, EXP, 1, 0, 0);
        push(m2 + W + 1, ST_RUN, EXP, 1, 1, 0);
`else
        push(f + 50, ST_FAULT, fault_fc, 0, 0, 1);
        push(m2 + W + 1, ST_FAULT, fault_fc, 0, 0, 1);
`endif
      end
    end
    if (max_rel + 3 >= MAXC) $fatal(1, "FAIL plan_length scen%0d: %0d exceeds %0d", scen, max_rel, MAXC);
    for (int i = 0; i <= max_rel + 2; i++) begin
      pll_lock = lock_arr[i];
      if (flip_arr[i]) pll_tog = ~pll_tog;
      @(negedge clk);
    end
  endtask

  initial begin
    // Nominal: random in-range counts over four windows.
    for (int j = 0; j < 8; j++) c[j] = EXP - TOL + int'($urandom_range(2 * TOL, 0));
    run_scen(2, 4, c, 0, 0);
    // Band edges pass, then one above the band fails while in RUN.
    c = '{EXP - TOL, EXP + TOL, EXP, EXP + TOL + 1, EXP, EXP, EXP, EXP};
    run_scen(3, 4, c, 0, 0);
    // One below the band fails while in RUN.
    c = '{EXP, EXP - TOL - 1, EXP, EXP, EXP, EXP, EXP, EXP};
    run_scen(2, 2, c, 0, 0);
    // First window out of range fails from MEASURE.
    c = '{EXP + TOL + 1, EXP, EXP, EXP, EXP, EXP, EXP, EXP};
    run_scen(2, 1, c, 0, 0);
    // No lock at all.
    run_scen(-1, 0, c, 0, 0);
    // Lock glitch during SETTLE returns to WAIT_LOCK without a fault.
    for (int j = 0; j < 8; j++) c[j] = EXP - TOL + int'($urandom_range(2 * TOL, 0));
    run_scen(2, 2, c, 1, 0);
    // Lock glitch in RUN.
    run_scen(2, 3, c, 2, 1);
    // Lock loss on the final window cycle with a nominal count.
    c[1] = EXP;
    run_scen(2, 2, c, 3, 1);
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
